load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data-memory interface. Accepts one load/store request at a time from the core's MEM stage.
- Drives the word-indexed data memory's MemRead/MemWrite/direccion/escritura_datos and samples leer_datos.
- Handles RV32I byte/halfword/word loads with sign/zero extension. Byte/halfword stores use read-modify-write, because the memory has word-granular writes only.
- Returns the load result or an error flag to the core over a valid/ready response channel.

Parameters:
MEM_WORDS, 32, number of 32-bit words in the data memory; word index >= MEM_WORDS is out of range
ADDR_W, 32, width of byte address from core

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req_valid  in  1  core presents request
req_ready  out  1  LSU can accept request (IDLE only)
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data (low bits used for B/H)
rsp_valid  out  1  response available
rsp_ready  in  1  core accepts response
rsp_rdata  out  32  extended load data; 0 for stores/errors
rsp_err  out  1  misaligned, out-of-range or illegal funct3
MemRead  out  1  memory read enable
MemWrite  out  1  memory write enable (memory writes on rising clk)
direccion  out  32  word index = req_addr[ADDR_W-1:2], zero-extended
escritura_datos  out  32  word to write
leer_datos  in  32  combinational read data from memory

Behaviour:
- States: IDLE, LOAD, RMW_RD, STORE, RESP. Encoding comes from the package.
- Reset (reset=0, async):
  - state=IDLE; all latched request fields = 0.
  - rsp_rdata=0, rsp_err=0.
  - Outputs: req_ready=1, rsp_valid=0, MemRead=0, MemWrite=0, direccion=0, escritura_datos=0.
- Reset mid-operation: the transaction is abandoned, no response is issued, and MemWrite drops immediately. A store that had not reached its STORE edge must not modify memory.
- MemRead, MemWrite and req_ready are decoded purely from state. direccion and escritura_datos come only from registers.
- IDLE: req_ready=1. On req_valid&&req_ready, latch addr, funct3, wdata, write, then check in this order:
  - illegal funct3 (011/110/111; or 100/101 with write=1) -> err
  - misaligned (H with addr[0]!=0; W with addr[1:0]!=0) -> err
  - word index >= MEM_WORDS -> err
  - On err: go to RESP with rsp_err=1 and rsp_rdata=0. No memory access of any kind.
  - Else: load -> LOAD; SW -> STORE (escritura_datos=wdata); SB/SH -> RMW_RD.
- LOAD: MemRead=1. At the edge, capture leer_datos and extract by addr[1:0]:
  - B: sign-extend byte[8*addr[1:0]+7 : 8*addr[1:0]]
  - BU: zero-extend the same byte
  - H / HU: halfword at addr[1], sign- or zero-extended
  - W: whole word
  - -> RESP.
- RMW_RD: MemRead=1. At the edge, merge wdata[7:0] or wdata[15:0] into the selected lane of leer_datos, keep the other bytes unchanged, register the result into escritura_datos -> STORE.
- STORE: MemWrite=1 for exactly one cycle; MemRead=0 -> RESP.
- RESP: rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready; -> IDLE on rsp_valid&&rsp_ready. No new request is accepted in RESP (req_ready=0).
- Latency from the accept edge to rsp_valid high:
  - LW/LB/LH/LBU/LHU: 2 cycles
  - SW: 2 cycles
  - SB/SH: 3 cycles
  - error: 1 cycle
- Throughput: one transaction outstanding. The next accept is possible in the cycle after the response handshake.
- MemRead and MemWrite are never asserted in the same cycle.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state typedef/localparams for the five states
  - ERR cause encoding (reserved for a future cause output)
- One combinational sub-module, lsu_align: inputs word, addr[1:0], funct3, wdata; outputs extended load value and merged store word. Shared by the LOAD and RMW_RD paths.

Test Plan:
- Memory word 3 preloaded with 0x8899AABB. Load LB addr=0x0D -> rsp_rdata=0xFFFFFFAA, err=0, rsp_valid 2 cycles after accept. Load LBU addr=0x0D -> 0x000000AA.
- Word 3 = 0x8899AABB. SB addr=0x0E, wdata=0x12345677 -> one MemRead cycle, then one MemWrite cycle with escritura_datos=0x8877AABB, direccion=3. A following LW addr=0x0C returns 0x8877AABB.
- SH addr=0x02, wdata=0x0000BEEF onto word 0=0x11223344 -> word 0 becomes 0xBEEF3344. LH addr=0x02 returns 0xFFFFBEEF; LHU addr=0x02 returns 0x0000BEEF.
- Error cases, each -> rsp_err=1 one cycle after accept, MemRead=MemWrite=0 throughout:
  - LW addr=0x06 (misaligned)
  - SH addr=0x01 (misaligned)
  - LW addr=0x80 with MEM_WORDS=32 (out of range)
  - store with funct3=100 (illegal)
- Backpressure: hold rsp_ready=0 for 5 cycles after an LW -> rsp_valid and rsp_rdata stable, req_ready=0, a second req_valid is not accepted. Release rsp_ready -> IDLE next cycle, then the second request is accepted.
- Assert reset low during RMW_RD of SB to word 5 -> MemWrite never asserts, word 5 unchanged, rsp_valid=0. After release, req_ready=1 and a fresh LW of word 5 returns the original value.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RV32I funct3 codes for loads and stores
//   - FSM state encoding
//   - error cause encoding (only "none vs. any" leaves the block today;
//     the individual causes are kept for a future cause output)
//   - lsu_check: request legality check in priority order
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_STORE  = 3'd3,
    S_RESP   = 3'd4
  } lsu_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_FUNCT3   = 2'd1,
    ERR_MISALIGN = 2'd2,
    ERR_RANGE    = 2'd3
  } lsu_err_t;

  // Checks are ordered: illegal funct3 first, then alignment, then range.
  // Unsigned variants exist only for loads.
  function automatic lsu_err_t lsu_check(input logic       write,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo,
                                         input logic       range_bad);
    lsu_err_t cause;
    logic     legal;
    legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
            (!write && ((funct3 == F3_BU) || (funct3 == F3_HU)));
    cause = ERR_NONE;
    if (!legal)
      cause = ERR_FUNCT3;
    else if ((((funct3 == F3_H) || (funct3 == F3_HU)) && addr_lo[0]) ||
             ((funct3 == F3_W) && (addr_lo != 2'b00)))
      cause = ERR_MISALIGN;
    else if (range_bad)
      cause = ERR_RANGE;
    return cause;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic shared by the load and read-modify-write paths.
// Ports:
//   i_word    : word read from memory
//   i_addr_lo : byte offset within the word
//   i_funct3  : access size / signedness
//   i_wdata   : store data (low byte / halfword used for SB / SH)
//   o_load    : selected lane, sign- or zero-extended to 32 bits
//   o_merged  : i_word with the store lane replaced (i_wdata for SW)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_load = i_word;
    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load = {24'd0, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load = {16'd0, w_half};
      default: o_load = i_word;
    endcase
  end

  always_comb begin
    o_merged = i_word;
    case (i_funct3)
      F3_B:    o_merged[{i_addr_lo, 3'b000} +: 8]      = i_wdata[7:0];
      F3_H:    o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of a word-indexed data memory.
// Accepts one request at a time, performs RV32I B/H/W loads with extension,
// and implements B/H stores as read-modify-write because the memory only
// writes whole words.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; the initiator holds its payload stable while valid && !ready.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   req_*           : request channel from the core (valid/ready)
//   rsp_*           : response channel to the core (valid/ready)
//   MemRead/MemWrite: memory strobes, decoded from state only
//   direccion       : word index of the latched address
//   escritura_datos : registered write word
//   leer_datos      : combinational memory read data
//   dbg_state       : current FSM state
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 32,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [31:0]       direccion,
  output logic [31:0]       escritura_datos,
  input  logic [31:0]       leer_datos,
  output logic [2:0]        dbg_state
);

  lsu_state_t        r_state;
  lsu_state_t        w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_funct3;
  logic [31:0]       r_wdata;
  logic              r_write;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [31:0]       r_wr_data;

  logic [ADDR_W-3:0] w_idx;
  logic              w_range_bad;
  lsu_err_t          w_cause;
  logic              w_accept;
  logic [31:0]       w_load;
  logic [31:0]       w_merged;

  assign w_idx       = req_addr[ADDR_W-1:2];
  assign w_range_bad = (64'(w_idx) >= 64'(MEM_WORDS));
  assign w_cause     = lsu_check(req_write, req_funct3, req_addr[1:0], w_range_bad);
  assign w_accept    = req_valid && (r_state == S_IDLE);

  lsu_align u_align (
    .i_word    (leer_datos),
    .i_addr_lo (r_addr[1:0]),
    .i_funct3  (r_funct3),
    .i_wdata   (r_wdata),
    .o_load    (w_load),
    .o_merged  (w_merged)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_cause != ERR_NONE)   w_next_state = S_RESP;
          else if (!req_write)       w_next_state = S_LOAD;
          else if (req_funct3 == F3_W) w_next_state = S_STORE;
          else                       w_next_state = S_RMW_RD;
        end
      end
      S_LOAD: begin
        MemRead      = 1'b1;
        w_next_state = S_RESP;
      end
      S_RMW_RD: begin
        MemRead      = 1'b1;
        w_next_state = S_STORE;
      end
      S_STORE: begin
        MemWrite     = 1'b1;
        w_next_state = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr    <= '0;
      r_funct3  <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_wr_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr   <= req_addr;
            r_funct3 <= req_funct3;
            r_wdata  <= req_wdata;
            r_write  <= req_write;
            // Stores and errors respond with zero data.
            r_rdata  <= '0;
            r_err    <= (w_cause != ERR_NONE);
            if ((w_cause == ERR_NONE) && req_write && (req_funct3 == F3_W))
              r_wr_data <= req_wdata;
          end
        end
        S_LOAD: begin
          if (!r_write) r_rdata <= w_load;
        end
        S_RMW_RD: r_wr_data <= w_merged;
        default: ;
      endcase
    end
  end

  assign direccion       = 32'(r_addr[ADDR_W-1:2]);
  assign escritura_datos = r_wr_data;
  assign rsp_rdata       = r_rdata;
  assign rsp_err         = r_err;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int MEM_WORDS = 32;
  localparam int EXP_W     = 41; // {nwr[1:0], nrd[1:0], lat[3:0], err, rdata[31:0]}

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        MemRead, MemWrite;
  logic [31:0] direccion, escritura_datos, leer_datos;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  load_store_unit #(.MEM_WORDS(MEM_WORDS), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .MemRead(MemRead), .MemWrite(MemWrite),
    .direccion(direccion), .escritura_datos(escritura_datos),
    .leer_datos(leer_datos), .dbg_state(dbg_state)
  );

  // ---------------- memory environment ----------------
  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'h11223344;
    if (i == 3) return 32'h8899AABB;
    return (32'(i) * 32'h01030507) ^ 32'h5A5AA5A5;
  endfunction

  logic [31:0] mem [MEM_WORDS];
  logic        init_done = 1'b0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_word(i);
    end else if (MemWrite && (direccion < 32'(MEM_WORDS))) begin
      mem[direccion[4:0]] <= escritura_datos;
    end
  end

  always_comb leer_datos = (direccion < 32'(MEM_WORDS)) ? mem[direccion[4:0]] : 32'hDEADBEEF;

  // ---------------- scoreboard state ----------------
  logic [7:0]       ref_b [MEM_WORDS*4];
  logic [EXP_W-1:0] exp_q[$];
  logic [63:0]      wr_q[$];
  int total = 0;
  int bad   = 0;
  int accept_cyc = 0;
  int hs_cyc = 0;
  int hold_cnt = 0;
  int rand_ready = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_b[idx*4+3], ref_b[idx*4+2], ref_b[idx*4+1], ref_b[idx*4]};
  endfunction

  // ---------------- driver ----------------
  // Computes the expected response from byte-level rules, then offers the
  // request until it is accepted.
  task automatic issue(input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    int size, lat, nrd, nwr, w;
    logic err;
    logic [31:0] val;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    err = (size == 0) || (wr && f3[2]);
    if (!err && ((addr % size) != 0)) err = 1'b1;
    if (!err && ((addr >> 2) >= 32'(MEM_WORDS))) err = 1'b1;
    val = 32'd0;
    if (err) begin
      lat = 1; nrd = 0; nwr = 0;
    end else if (!wr) begin
      for (int k = size - 1; k >= 0; k--) val = (val << 8) | 32'(ref_b[int'(addr) + k]);
      if (!f3[2] && (size < 4) && val[8*size-1]) val = val | ~((32'd1 << (8*size)) - 32'd1);
      lat = 2; nrd = 1; nwr = 0;
    end else begin
      for (int k = 0; k < size; k++) ref_b[int'(addr) + k] = wd[8*k +: 8];
      wr_q.push_back({addr >> 2, ref_word(int'(addr >> 2))});
      lat = (size == 4) ? 2 : 3;
      nrd = (size == 4) ? 0 : 1;
      nwr = 1;
    end
    exp_q.push_back({2'(nwr), 2'(nrd), 4'(lat), err, val});

    w = 0;
    forever begin
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      if (req_ready) break;
      w++;
      if (w > 50) begin
        $display("FAIL accept_timeout: got no req_ready want req_ready within 50 cycles");
        $fatal(1, "request never accepted");
      end
    end
    accept_cyc = cyc + 1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || !req_ready) && w < 200) begin
      @(negedge clk);
      w++;
    end
    cmp("drain_timeout", 32'(w >= 200), 32'd0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    int rd_cnt, wr_cnt, lat;
    logic prev_valid, prev_stall, prev_err;
    logic [31:0] prev_data;
    logic [EXP_W-1:0] e;
    logic [63:0] we;
    rd_cnt = 0; wr_cnt = 0; prev_valid = 0; prev_stall = 0; prev_err = 0; prev_data = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        rd_cnt = 0; wr_cnt = 0; prev_valid = 0; prev_stall = 0;
        rsp_ready = 1'b0;
        continue;
      end
      cmp("rd_wr_exclusive", 32'(MemRead && MemWrite), 32'd0);
      if (MemRead) rd_cnt++;
      if (MemWrite) begin
        wr_cnt++;
        if (wr_q.size() == 0) begin
          cmp("unexpected_write", 32'd1, 32'd0);
        end else begin
          we = wr_q.pop_front();
          cmp("write_index", direccion, we[63:32]);
          cmp("write_data", escritura_datos, we[31:0]);
        end
      end
      if (prev_stall) begin
        cmp("hold_valid", 32'(rsp_valid), 32'd1);
        cmp("hold_rdata", rsp_rdata, prev_data);
        cmp("hold_err", 32'(rsp_err), 32'(prev_err));
        cmp("hold_req_ready", 32'(req_ready), 32'd0);
      end
      if (rsp_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          cmp("unexpected_response", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          lat = cyc - accept_cyc + 1;
          cmp("rsp_rdata", rsp_rdata, e[31:0]);
          cmp("rsp_err", 32'(rsp_err), 32'(e[32]));
          cmp("latency", 32'(lat), 32'(e[36:33]));
          cmp("memread_cycles", 32'(rd_cnt), 32'(e[38:37]));
          cmp("memwrite_cycles", 32'(wr_cnt), 32'(e[40:39]));
        end
        rd_cnt = 0; wr_cnt = 0;
      end
      if (hold_cnt > 0 && rsp_valid) begin
        rsp_ready = 1'b0;
        hold_cnt--;
      end else begin
        rsp_ready = (rand_ready != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (rsp_valid && rsp_ready) hs_cyc = cyc + 1;
      prev_stall = rsp_valid && !rsp_ready;
      prev_valid = rsp_valid;
      prev_data  = rsp_rdata;
      prev_err   = rsp_err;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] w5;
    for (int i = 0; i < MEM_WORDS; i++)
      for (int k = 0; k < 4; k++) begin
        w5 = init_word(i);
        ref_b[i*4+k] = w5[8*k +: 8];
      end
    #3;
    cmp("rst_req_ready", 32'(req_ready), 32'd1);
    cmp("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    cmp("rst_memread", 32'(MemRead), 32'd0);
    cmp("rst_memwrite", 32'(MemWrite), 32'd0);
    cmp("rst_direccion", direccion, 32'd0);
    cmp("rst_escritura", escritura_datos, 32'd0);
    cmp("rst_rdata", rsp_rdata, 32'd0);
    cmp("rst_err", 32'(rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 init_done = 1'b1;
    @(negedge clk);
    reset = 1'b1;

    // loads with sign/zero extension
    issue(1'b0, F3_B,  32'h0D, 32'h0);
    issue(1'b0, F3_BU, 32'h0D, 32'h0);
    // byte store via read-modify-write, then read back
    issue(1'b1, F3_B,  32'h0E, 32'h12345677);
    issue(1'b0, F3_W,  32'h0C, 32'h0);
    // halfword store and loads
    issue(1'b1, F3_H,  32'h02, 32'h0000BEEF);
    issue(1'b0, F3_H,  32'h02, 32'h0);
    issue(1'b0, F3_HU, 32'h02, 32'h0);
    // error cases
    issue(1'b0, F3_W,  32'h06, 32'h0);
    issue(1'b1, F3_H,  32'h01, 32'h0);
    issue(1'b0, F3_W,  32'h80, 32'h0);
    issue(1'b1, F3_BU, 32'h10, 32'hFFFFFFFF);
    drain();
    cmp("mem3_after_sb", mem[3], 32'h8877AABB);
    cmp("mem0_after_sh", mem[0], 32'hBEEF3344);

    // backpressure: 5 stalled cycles, second request waits for the handshake
    hold_cnt = 5;
    issue(1'b0, F3_W, 32'h0C, 32'h0);
    issue(1'b0, F3_W, 32'h00, 32'h0);
    cmp("bp_accept_cycle", 32'(accept_cyc), 32'(hs_cyc + 1));
    drain();

    // reset during RMW_RD of a byte store to word 5
    w5 = ref_word(5);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_B;
    req_addr = 32'h15; req_wdata = $urandom;
    cmp("rmw_pre_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    cmp("rmw_state", 32'(dbg_state), 32'(S_RMW_RD));
    #1 reset = 1'b0;
    #1;
    cmp("rstmid_memwrite", 32'(MemWrite), 32'd0);
    cmp("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    cmp("rstmid_req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    cmp("word5_unchanged", mem[5], w5);
    issue(1'b0, F3_W, 32'h14, 32'h0);
    drain();

    // randomized traffic with random response backpressure
    rand_ready = 1;
    for (int n = 0; n < 150; n++) begin
      logic wr;
      logic [2:0] f3;
      logic [31:0] a;
      int sel;
      wr  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      if (sel < 8)       a = $urandom_range(0, MEM_WORDS*4 - 1);
      else if (sel == 8) a = $urandom_range(MEM_WORDS*4, 255);
      else               a = $urandom;
      issue(wr, f3, a, $urandom);
    end
    drain();
    cmp("exp_q_empty", 32'(exp_q.size()), 32'd0);
    cmp("wr_q_empty", 32'(wr_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
